// File: rtl/serial_fourbits_subtractor.sv
// ---------------------------------------------------------------------------
// serial_fourbits_subtractor
//
// Bit-serial subtractor computing diff = a - b - borrow_in, LSB first, one bit
// per clock. It is the sequential counterpart of the combinational 4-bit adder
// in the arithmetic datapath. Both use the same borrow convention, so the
// adder can cross-check results with a = diff + b + borrow_in.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     request; only accepted in IDLE or DONE
//   a_i         minuend, captured on accepted start
//   b_i         subtrahend, captured on accepted start
//   borrow_i    borrow-in, captured on accepted start
//   diff_o      registered result, held until next completion or reset
//   borrow_o    registered borrow-out (1 = a < b + borrow_i, unsigned)
//   busy_o      high while bits are being shifted
//   done_o      one-cycle pulse when diff_o/borrow_o are updated
//   overflow_o  signed overflow flag (only with SUB_OVERFLOW_FLAG_EN)
//
// Optional feature macro: SUB_OVERFLOW_FLAG_EN adds the overflow_o output.
// ---------------------------------------------------------------------------
module serial_fourbits_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             overflow_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] shiftA_q, shiftA_d;
  logic [WIDTH-1:0] shiftB_q, shiftB_d;
  logic             bitBorrow_q, bitBorrow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-2:0] partial_q, partial_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrowOut_q, borrowOut_d;

`ifdef SUB_OVERFLOW_FLAG_EN
  logic             msbA_q, msbA_d;
  logic             msbB_q, msbB_d;
  logic             overflow_q, overflow_d;
`endif

  logic             diffBit;
  logic             nextBorrow;
  logic [WIDTH-1:0] shiftedResult;
  logic             accept;
  logic             lastBit;

  // One full-subtractor slice working on the current LSBs of the captured
  // operands. The result register only keeps WIDTH-1 bits: the bit produced
  // in the final shift cycle goes straight into diff_o together with the
  // bits gathered so far, so no extra storage cycle is needed.
  always_comb begin
    diffBit       = shiftA_q[0] ^ shiftB_q[0] ^ bitBorrow_q;
    nextBorrow    = (~shiftA_q[0] & shiftB_q[0]) |
                    (~(shiftA_q[0] ^ shiftB_q[0]) & bitBorrow_q);
    shiftedResult = {diffBit, partial_q};
    accept        = start_i && ((state_q == IDLE) || (state_q == DONE));
    lastBit       = (count_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath update. Everything holds by default; a start is
  // honoured in IDLE and in DONE so operations can run back-to-back, and it
  // is ignored while shifting. The published result only changes on the
  // final shift cycle, never part-way through an operation.
  always_comb begin
    state_d     = state_q;
    shiftA_d    = shiftA_q;
    shiftB_d    = shiftB_q;
    bitBorrow_d = bitBorrow_q;
    count_d     = count_q;
    partial_d   = partial_q;
    diff_d      = diff_q;
    borrowOut_d = borrowOut_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    msbA_d      = msbA_q;
    msbB_d      = msbB_q;
    overflow_d  = overflow_q;
`endif

    case (state_q)
      SHIFT: begin
        shiftA_d    = shiftA_q >> 1;
        shiftB_d    = shiftB_q >> 1;
        bitBorrow_d = nextBorrow;
        partial_d   = shiftedResult[WIDTH-1:1];
        count_d     = count_q + CNT_W'(1);
        if (lastBit) begin
          state_d     = DONE;
          diff_d      = shiftedResult;
          borrowOut_d = nextBorrow;
`ifdef SUB_OVERFLOW_FLAG_EN
          overflow_d  = (msbA_q != msbB_q) && (diffBit != msbA_q);
`endif
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          state_d     = SHIFT;
          shiftA_d    = a_i;
          shiftB_d    = b_i;
          bitBorrow_d = borrow_i;
          count_d     = '0;
          partial_d   = '0;
`ifdef SUB_OVERFLOW_FLAG_EN
          msbA_d      = a_i[WIDTH-1];
          msbB_d      = b_i[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over everything, including an
  // operation in flight, and clears the published result as well.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shiftA_q    <= '0;
      shiftB_q    <= '0;
      bitBorrow_q <= 1'b0;
      count_q     <= '0;
      partial_q   <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      msbA_q      <= 1'b0;
      msbB_q      <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shiftA_q    <= shiftA_d;
      shiftB_q    <= shiftB_d;
      bitBorrow_q <= bitBorrow_d;
      count_q     <= count_d;
      partial_q   <= partial_d;
      diff_q      <= diff_d;
      borrowOut_q <= borrowOut_d;
`ifdef SUB_OVERFLOW_FLAG_EN
      msbA_q      <= msbA_d;
      msbB_q      <= msbB_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  // Status flags come straight from the registered state, so they are
  // glitch-free and line up with the registered result.
  always_comb begin
    diff_o   = diff_q;
    borrow_o = borrowOut_q;
    busy_o   = (state_q == SHIFT);
    done_o   = (state_q == DONE);
`ifdef SUB_OVERFLOW_FLAG_EN
    overflow_o = overflow_q;
`endif
  end

endmodule

// File: tb/tb_serial_fourbits_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_fourbits_subtractor
//
// Self-checking bench for serial_fourbits_subtractor (WIDTH = 4). A table of
// directed operand sets with hand-computed results runs first. Hand-written
// sequences follow for back-to-back starts, reset mid-operation and a start
// request during shifting. The overflow flag is checked only when
// SUB_OVERFLOW_FLAG_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_fourbits_subtractor;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       borrow_i;
  logic [3:0] diff_o;
  logic       borrow_o;
  logic       busy_o;
  logic       done_o;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic       overflow_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] expDiff;
    logic       expBorrow;
    logic       expOvf;
  } vector_t;

  vector_t vectors[10];

  serial_fourbits_subtractor #(
    .WIDTH(4),
    .CNT_W(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .borrow_i  (borrow_i),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .overflow_o(overflow_o)
`endif
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Last-resort guard in case something stalls outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Launches one operation and returns at the negedge where done_o is seen,
  // or after a bounded wait. The operand inputs are scrambled after capture
  // because the design must not depend on them any more.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic bin, output int busyCycles,
                               output bit doneSeen);
    @(negedge clk_i);
    a_i      = a;
    b_i      = b;
    borrow_i = bin;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    a_i      = ~a;
    b_i      = ~b;
    borrow_i = ~bin;
    busyCycles = 0;
    doneSeen   = 1'b0;
    for (int i = 0; i < 20 && !doneSeen; i++) begin
      if (done_o) begin
        doneSeen = 1'b1;
      end else begin
        if (busy_o) busyCycles++;
        @(negedge clk_i);
      end
    end
  endtask

  initial begin
    int         busyCycles;
    bit         doneSeen;
    int         waited;
    int         doneCount;
    logic [3:0] heldDiff;
    logic       heldBorrow;

    vectors[0] = '{a: 4'b0111, b: 4'b0001, bin: 1'b0, expDiff: 4'b0110, expBorrow: 1'b0, expOvf: 1'b0};
    vectors[1] = '{a: 4'b0000, b: 4'b0001, bin: 1'b0, expDiff: 4'b1111, expBorrow: 1'b1, expOvf: 1'b0};
    vectors[2] = '{a: 4'b1111, b: 4'b1111, bin: 1'b1, expDiff: 4'b1111, expBorrow: 1'b1, expOvf: 1'b0};
    vectors[3] = '{a: 4'b0101, b: 4'b0010, bin: 1'b0, expDiff: 4'b0011, expBorrow: 1'b0, expOvf: 1'b0};
    vectors[4] = '{a: 4'b0011, b: 4'b0101, bin: 1'b0, expDiff: 4'b1110, expBorrow: 1'b1, expOvf: 1'b0};
    vectors[5] = '{a: 4'b1000, b: 4'b0001, bin: 1'b0, expDiff: 4'b0111, expBorrow: 1'b0, expOvf: 1'b1};
    vectors[6] = '{a: 4'b0000, b: 4'b0000, bin: 1'b1, expDiff: 4'b1111, expBorrow: 1'b1, expOvf: 1'b0};
    vectors[7] = '{a: 4'b1001, b: 4'b0010, bin: 1'b1, expDiff: 4'b0110, expBorrow: 1'b0, expOvf: 1'b1};
    vectors[8] = '{a: 4'b0111, b: 4'b1000, bin: 1'b0, expDiff: 4'b1111, expBorrow: 1'b1, expOvf: 1'b1};
    vectors[9] = '{a: 4'b1010, b: 4'b0011, bin: 1'b0, expDiff: 4'b0111, expBorrow: 1'b0, expOvf: 1'b1};

    rst_i    = 1'b1;
    start_i  = 1'b0;
    a_i      = 4'b0;
    b_i      = 4'b0;
    borrow_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset diff_o", 32'(diff_o), 32'h0);
    checkOutput("reset borrow_o", 32'(borrow_o), 32'h0);
    checkOutput("reset busy_o", 32'(busy_o), 32'h0);
    checkOutput("reset done_o", 32'(done_o), 32'h0);
`ifdef SUB_OVERFLOW_FLAG_EN
    checkOutput("reset overflow_o", 32'(overflow_o), 32'h0);
`endif

    // Directed table
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vectors[v].a, vectors[v].b, vectors[v].bin, busyCycles, doneSeen);
      checkOutput($sformatf("vec%0d done seen", v), 32'(doneSeen), 32'h1);
      checkOutput($sformatf("vec%0d busy cycles", v), 32'(busyCycles), 32'd4);
      checkOutput($sformatf("vec%0d diff_o", v), 32'(diff_o), 32'(vectors[v].expDiff));
      checkOutput($sformatf("vec%0d borrow_o", v), 32'(borrow_o), 32'(vectors[v].expBorrow));
`ifdef SUB_OVERFLOW_FLAG_EN
      checkOutput($sformatf("vec%0d overflow_o", v), 32'(overflow_o), 32'(vectors[v].expOvf));
`endif
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d done pulse width", v), 32'(done_o), 32'h0);
      checkOutput($sformatf("vec%0d diff held", v), 32'(diff_o), 32'(vectors[v].expDiff));
    end

    // Back-to-back: start held, second operands presented in the DONE cycle
    @(negedge clk_i);
    a_i      = 4'b0001;
    b_i      = 4'b0000;
    borrow_i = 1'b0;
    start_i  = 1'b1;
    waited   = 0;
    while (!done_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("b2b first done", 32'(done_o), 32'h1);
    checkOutput("b2b first diff_o", 32'(diff_o), 32'h1);
    checkOutput("b2b first borrow_o", 32'(borrow_o), 32'h0);
    a_i = 4'b1000;
    b_i = 4'b0001;
    @(negedge clk_i);
    start_i = 1'b0;
    waited  = 1;
    checkOutput("b2b restarted busy", 32'(busy_o), 32'h1);
    while (!done_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("b2b second spacing", 32'(waited), 32'd5);
    checkOutput("b2b second diff_o", 32'(diff_o), 32'h7);
    checkOutput("b2b second borrow_o", 32'(borrow_o), 32'h0);
`ifdef SUB_OVERFLOW_FLAG_EN
    checkOutput("b2b second overflow_o", 32'(overflow_o), 32'h1);
`endif

    // Reset mid-operation, after a result that left nonzero outputs
    applyStimulus(4'b0000, 4'b0001, 1'b0, busyCycles, doneSeen);
    checkOutput("pre-reset borrow_o", 32'(borrow_o), 32'h1);
    @(negedge clk_i);
    a_i      = 4'b1010;
    b_i      = 4'b0011;
    borrow_i = 1'b0;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midreset busy_o", 32'(busy_o), 32'h0);
    checkOutput("midreset done_o", 32'(done_o), 32'h0);
    checkOutput("midreset diff_o", 32'(diff_o), 32'h0);
    checkOutput("midreset borrow_o", 32'(borrow_o), 32'h0);
`ifdef SUB_OVERFLOW_FLAG_EN
    checkOutput("midreset overflow_o", 32'(overflow_o), 32'h0);
`endif
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o) doneCount++;
      @(negedge clk_i);
    end
    checkOutput("midreset no done", 32'(doneCount), 32'd0);

    // Start request during SHIFT must be ignored
    a_i      = 4'b0101;
    b_i      = 4'b0010;
    borrow_i = 1'b0;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    a_i     = 4'b1111;
    b_i     = 4'b1010;
    @(negedge clk_i);
    start_i    = 1'b0;
    doneCount  = 0;
    heldDiff   = 4'b0;
    heldBorrow = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done_o) begin
        doneCount++;
        heldDiff   = diff_o;
        heldBorrow = borrow_o;
      end
      @(negedge clk_i);
    end
    checkOutput("ignored start done count", 32'(doneCount), 32'd1);
    checkOutput("ignored start diff_o", 32'(heldDiff), 32'h3);
    checkOutput("ignored start borrow_o", 32'(heldBorrow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
